// File: rtl/cam_frame_capture.sv
// Camera capture front-end: frame/row/column tracking, crop window, power-of-two decimation, FWFT pixel FIFO.
// Define CAP_TIMEOUT_EN to add the vsync watchdog and its sticky timeout output.
module cam_frame_capture #(
    parameter int DATA_W      = 8,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9,
    parameter int FIFO_DEPTH  = 16,
    parameter int FCNT_W      = 16,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cont_mode,
    input  logic [COL_W-1:0]  win_x0,
    input  logic [ROW_W-1:0]  win_y0,
    input  logic [COL_W-1:0]  win_w,
    input  logic [ROW_W-1:0]  win_h,
    input  logic [1:0]        decim,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count,
    output logic              overflow,
`ifdef CAP_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic [7:0]        drop_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = DATA_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_VS_HIGH, S_CAPTURE, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic               cont_reg, stop_pend_reg, sof_pend_reg, href_q_reg;
    logic [COL_W-1:0]   x0_reg, w_reg, col_reg;
    logic [ROW_W-1:0]   y0_reg, h_reg, row_reg;
    logic [1:0]         decim_reg;
    logic               frame_done_reg, overflow_reg;
    logic [FCNT_W-1:0]  frame_count_reg;
    logic [7:0]         drop_count_reg;
    logic               timeout_hit, frame_end;

    // Window offsets are one bit wider so a pixel left of / above the window never wraps into it.
    logic [COL_W:0]     dx;
    logic [ROW_W:0]     dy;
    logic [COL_W+1:0]   step_w;
    logic [1:0]         dmask;
    logic               pix_stb, in_win, accept, eol;

    assign pix_stb = href & pix_valid;
    assign dx      = {1'b0, col_reg} - {1'b0, x0_reg};
    assign dy      = {1'b0, row_reg} - {1'b0, y0_reg};
    assign step_w  = (COL_W+2)'(1) << decim_reg;
    assign dmask   = (decim_reg == 2'd0) ? 2'b00 : (decim_reg == 2'd1) ? 2'b01 : 2'b11;
    assign in_win  = (col_reg >= x0_reg) && (row_reg >= y0_reg) &&
                     (dx < {1'b0, w_reg}) && (dy < {1'b0, h_reg}) &&
                     ((dx[1:0] & dmask) == 2'b00) && ((dy[1:0] & dmask) == 2'b00);
    assign accept  = (state_reg == S_CAPTURE) && pix_stb && in_win;
    assign eol     = ({1'b0, dx} + step_w) >= {2'b00, w_reg};

    // FIFO: pointers carry a wrap bit; head_reg is the registered RAM read, with write bypass.
    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [WORD_W-1:0]  head_reg, wr_word;
    logic               empty, full, pop, push, drop;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign pop         = !empty && out_ready;
    assign push        = accept && (!full || pop);
    assign drop        = accept && full && !pop;
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
    assign wr_word     = {sof_pend_reg, eol, pix_data};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            if (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                head_reg <= wr_word;
            end else begin
                head_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start) state_next = S_WAIT_VS;
            S_WAIT_VS: begin
                if (stop || stop_pend_reg) state_next = S_IDLE;
                else if (vsync)            state_next = S_VS_HIGH;
            end
            S_VS_HIGH: begin
                if (stop || stop_pend_reg) state_next = S_IDLE;
                else if (!vsync)           state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (vsync) state_next = (cont_reg && !stop_pend_reg && !stop) ? S_VS_HIGH : S_DONE;
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_IDLE;
    end

    assign frame_end = (state_reg == S_CAPTURE) && vsync && !timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cont_reg        <= 1'b0;
            stop_pend_reg   <= 1'b0;
            sof_pend_reg    <= 1'b0;
            href_q_reg      <= 1'b0;
            x0_reg          <= '0;
            y0_reg          <= '0;
            w_reg           <= '0;
            h_reg           <= '0;
            decim_reg       <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
            overflow_reg    <= 1'b0;
            drop_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            href_q_reg     <= href;
            frame_done_reg <= frame_end;
            if (frame_end) begin
                frame_count_reg <= frame_count_reg + FCNT_W'(1);
            end

            if ((state_reg == S_IDLE) && start) begin
                cont_reg       <= cont_mode;
                x0_reg         <= win_x0;
                y0_reg         <= win_y0;
                w_reg          <= win_w;
                h_reg          <= win_h;
                decim_reg      <= (decim == 2'd3) ? 2'd2 : decim;
                overflow_reg   <= 1'b0;
                drop_count_reg <= '0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
            end

            if (state_next == S_IDLE) begin
                stop_pend_reg <= 1'b0;
            end else if (stop && (state_reg != S_IDLE)) begin
                stop_pend_reg <= 1'b1;
            end

            if ((state_reg == S_VS_HIGH) && (state_next == S_CAPTURE)) begin
                row_reg      <= '0;
                col_reg      <= '0;
                sof_pend_reg <= 1'b1;
            end else if (state_reg == S_CAPTURE) begin
                if (push) sof_pend_reg <= 1'b0;
                if (pix_stb && (col_reg != '1)) begin
                    col_reg <= col_reg + COL_W'(1);
                end else if (href_q_reg && !href) begin
                    col_reg <= '0;
                    if (row_reg != '1) row_reg <= row_reg + ROW_W'(1);
                end
            end
        end
    end

`ifdef CAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_reg;
    logic          vsync_q_reg, timeout_reg, to_active;

    assign to_active   = (state_reg == S_WAIT_VS) || (state_reg == S_VS_HIGH) || (state_reg == S_CAPTURE);
    assign timeout_hit = to_active && (to_cnt_reg == TW'(TIMEOUT_CYC - 1));
    assign timeout     = timeout_reg;

    // Any vsync transition proves the camera is alive and restarts the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg  <= '0;
            vsync_q_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            vsync_q_reg <= vsync;
            if (!to_active || (vsync != vsync_q_reg)) to_cnt_reg <= '0;
            else                                      to_cnt_reg <= to_cnt_reg + TW'(1);
            if ((state_reg == S_IDLE) && start) timeout_reg <= 1'b0;
            else if (timeout_hit)               timeout_reg <= 1'b1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_hit    = 1'b0;
    assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

    assign out_valid   = !empty;
    assign out_data    = head_reg[DATA_W-1:0];
    assign out_eol     = head_reg[DATA_W];
    assign out_sof     = head_reg[DATA_W+1];
    assign busy        = (state_reg != S_IDLE);
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
    assign overflow    = overflow_reg;
    assign drop_count  = drop_count_reg;

endmodule
